// File: rtl/pipeline_hazard_sequencer_if.sv
// ID/EX stage fields and pipeline control returned to the datapath.
// master: the datapath side that drives the stage fields. slave: the sequencer.
interface pipeline_hazard_sequencer_if #(
    parameter int REG_AW = 4,
    parameter int CNT_W  = 16
);
    logic              id_valid;
    logic [3:0]        id_opcode;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_uses_rs2;
    logic              ex_is_load;
    logic              ex_reg_write;
    logic [REG_AW-1:0] ex_rd;
    logic              error_flag;

    logic              stall_fetch;
    logic              bubble_ex;
    logic              ex_hold;
    logic              div_start;
    logic              div_done;
    logic              halted;
    logic [1:0]        state;
    logic [CNT_W-1:0]  stall_count;

    modport master (
        output id_valid, id_opcode, id_rs1, id_rs2, id_uses_rs2,
               ex_is_load, ex_reg_write, ex_rd, error_flag,
        input  stall_fetch, bubble_ex, ex_hold, div_start, div_done,
               halted, state, stall_count
    );

    modport slave (
        input  id_valid, id_opcode, id_rs1, id_rs2, id_uses_rs2,
               ex_is_load, ex_reg_write, ex_rd, error_flag,
        output stall_fetch, bubble_ex, ex_hold, div_start, div_done,
               halted, state, stall_count
    );
endinterface

// File: rtl/pipeline_hazard_sequencer.sv
// Purpose: stall/bubble/hold sequencing for load-use hazards, multi-cycle divides and error halt.
// Latency: controls are combinational from the current state and ID/EX fields; state moves one edge later.
// Backpressure: stall_fetch freezes PC and IF/ID; ex_hold freezes EX for the divide; HALT holds until reset.
module pipeline_hazard_sequencer #(
    parameter int         REG_AW     = 4,
    parameter logic [3:0] DIV_OPCODE = 4'b0011,
    parameter int         DIV_CYCLES = 8,
    parameter int         CNT_W      = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    pipeline_hazard_sequencer_if.slave   bus
);

    localparam logic [1:0] ST_RUN  = 2'b00;
    localparam logic [1:0] ST_DIV  = 2'b01;
    localparam logic [1:0] ST_HALT = 2'b11;

    localparam logic [3:0] DIV_LOAD = 4'(DIV_CYCLES - 1);

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [3:0]       cnt_q;
    logic [3:0]       cnt_d;
    logic [CNT_W-1:0] stall_cnt_q;

    logic hazard;
    logic rs1_match;
    logic rs2_match;
    logic is_div;
    logic sf;
    logic bub;
    logic hold;
    logic ds;
    logic dd;
    logic hl;

    assign rs1_match = (bus.ex_rd == bus.id_rs1);
    assign rs2_match = bus.id_uses_rs2 && (bus.ex_rd == bus.id_rs2);
    assign hazard    = bus.id_valid && bus.ex_is_load && bus.ex_reg_write
                       && (bus.ex_rd != '0) && (rs1_match || rs2_match);
    assign is_div    = bus.id_valid && (bus.id_opcode == DIV_OPCODE);

    always_comb begin
        sf      = 1'b0;
        bub     = 1'b0;
        hold    = 1'b0;
        ds      = 1'b0;
        dd      = 1'b0;
        hl      = 1'b0;
        state_d = state_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_DIV: begin
                // ID is frozen while the divider owns EX, so no hazard check here.
                sf   = 1'b1;
                hold = 1'b1;
                if (bus.error_flag) begin
                    state_d = ST_HALT;
                    cnt_d   = '0;
                end else if (cnt_q == 4'd1) begin
                    dd      = 1'b1;
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_HALT: begin
                sf      = 1'b1;
                bub     = 1'b1;
                hl      = 1'b1;
                state_d = ST_HALT;
            end
            default: begin
                // Hazard beats divide issue; the divide re-presents after the bubble.
                if (hazard) begin
                    sf  = 1'b1;
                    bub = 1'b1;
                end else if (is_div) begin
                    ds      = 1'b1;
                    state_d = ST_DIV;
                    cnt_d   = DIV_LOAD;
                end else begin
                    state_d = ST_RUN;
                end
                if (bus.error_flag) begin
                    state_d = ST_HALT;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_RUN;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (sf && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
        end
    end

    assign bus.stall_fetch = sf   && !reset;
    assign bus.bubble_ex   = bub  && !reset;
    assign bus.ex_hold     = hold && !reset;
    assign bus.div_start   = ds   && !reset;
    assign bus.div_done    = dd   && !reset;
    assign bus.halted      = hl   && !reset;
    assign bus.state       = reset ? 2'b00 : state_q;
    assign bus.stall_count = reset ? '0 : stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_sequencer.sv
// Random and directed stimulus against a cycle-level reference model; a negedge monitor
// pops expected outputs and compares both a 16-bit and a 4-bit statistics counter instance.
module tb_pipeline_hazard_sequencer;

    localparam int DIVC = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipeline_hazard_sequencer_if #(.REG_AW(4), .CNT_W(16)) bus ();
    pipeline_hazard_sequencer_if #(.REG_AW(4), .CNT_W(4))  bus_s ();

    assign bus_s.id_valid     = bus.id_valid;
    assign bus_s.id_opcode    = bus.id_opcode;
    assign bus_s.id_rs1       = bus.id_rs1;
    assign bus_s.id_rs2       = bus.id_rs2;
    assign bus_s.id_uses_rs2  = bus.id_uses_rs2;
    assign bus_s.ex_is_load   = bus.ex_is_load;
    assign bus_s.ex_reg_write = bus.ex_reg_write;
    assign bus_s.ex_rd        = bus.ex_rd;
    assign bus_s.error_flag   = bus.error_flag;

    pipeline_hazard_sequencer #(.REG_AW(4), .DIV_OPCODE(4'b0011), .DIV_CYCLES(DIVC), .CNT_W(16)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    pipeline_hazard_sequencer #(.REG_AW(4), .DIV_OPCODE(4'b0011), .DIV_CYCLES(DIVC), .CNT_W(4)) dut_small (
        .clock (clk),
        .reset (rst),
        .bus   (bus_s)
    );

    typedef struct packed {
        logic        sf;
        logic        bub;
        logic        hold;
        logic        ds;
        logic        dd;
        logic        hl;
        logic [1:0]  st;
        logic [15:0] sc;
        logic [3:0]  scs;
    } obs_t;

    obs_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // Model: mode is what the pipeline is doing, div_left counts remaining frozen divide cycles.
    typedef enum int {M_RUN, M_DIV, M_HALT} mode_t;
    mode_t m_mode   = M_RUN;
    int    div_left = 0;
    int    stalls   = 0;

    function automatic int min_int(int a, int b);
        return (a < b) ? a : b;
    endfunction

    task automatic step();
        obs_t  e;
        bit    hz;
        bit    want_div;
        bit    err;
        mode_t nxt;
        e = '0;
        if (rst) begin
            m_mode   = M_RUN;
            div_left = 0;
            stalls   = 0;
        end else begin
            hz = bus.id_valid && bus.ex_is_load && bus.ex_reg_write && (bus.ex_rd != 0)
                 && ((bus.ex_rd == bus.id_rs1) || (bus.id_uses_rs2 && (bus.ex_rd == bus.id_rs2)));
            want_div = bus.id_valid && (bus.id_opcode == 4'd3);
            err = bus.error_flag;
            e.sc  = 16'(min_int(stalls, 65535));
            e.scs = 4'(min_int(stalls, 15));
            nxt = m_mode;
            if (m_mode == M_HALT) begin
                e.sf = 1; e.bub = 1; e.hl = 1; e.st = 2'b11;
            end else if (m_mode == M_DIV) begin
                e.sf = 1; e.hold = 1; e.st = 2'b01;
                e.dd = (div_left == 1) && !err;
                div_left = div_left - 1;
                if (err) nxt = M_HALT;
                else if (div_left == 0) nxt = M_RUN;
            end else begin
                e.st = 2'b00;
                if (hz) begin
                    e.sf = 1; e.bub = 1;
                end else if (want_div) begin
                    e.ds = 1;
                    div_left = DIVC - 1;
                    nxt = M_DIV;
                end
                if (err) nxt = M_HALT;
            end
            if (e.sf) stalls = stalls + 1;
            m_mode = nxt;
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        bus.id_valid     = 0;
        bus.id_opcode    = 0;
        bus.id_rs1       = 0;
        bus.id_rs2       = 0;
        bus.id_uses_rs2  = 0;
        bus.ex_is_load   = 0;
        bus.ex_reg_write = 0;
        bus.ex_rd        = 0;
        bus.error_flag   = 0;
    endtask

    task automatic set_load(input logic [3:0] rd);
        bus.ex_is_load   = 1;
        bus.ex_reg_write = 1;
        bus.ex_rd        = rd;
    endtask

    always @(negedge clk) begin : monitor
        obs_t e;
        obs_t a;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            a = {bus.stall_fetch, bus.bubble_ex, bus.ex_hold, bus.div_start, bus.div_done,
                 bus.halted, bus.state, bus.stall_count, bus_s.stall_count};
            tests++;
            if (a !== e) begin
                fails++;
                $display("FAIL outputs t=%0t got sf%b bub%b hold%b ds%b dd%b hl%b st%b sc%0d scs%0d want sf%b bub%b hold%b ds%b dd%b hl%b st%b sc%0d scs%0d",
                         $time, a.sf, a.bub, a.hold, a.ds, a.dd, a.hl, a.st, a.sc, a.scs,
                         e.sf, e.bub, e.hold, e.ds, e.dd, e.hl, e.st, e.sc, e.scs);
            end
        end
    end

    initial begin
        rst = 1;
        set_idle();
        @(posedge clk);
        #1;
        step();
        step();
        rst = 0;
        step();

        // load-use on rs1, then the bubbled EX no longer holds the load
        bus.id_valid = 1; bus.id_rs1 = 5; set_load(5);
        step();
        set_idle();
        step();
        bus.id_valid = 1; bus.id_rs1 = 0; set_load(0);
        step();

        // rs2 only counts when the instruction reads it
        set_idle();
        bus.id_valid = 1; bus.id_rs1 = 1; bus.id_rs2 = 7; set_load(7);
        step();
        bus.id_uses_rs2 = 1;
        step();
        set_idle();
        step();

        // plain divide
        bus.id_valid = 1; bus.id_opcode = 4'b0011;
        step();
        set_idle();
        repeat (DIVC) step();

        // hazard beats divide issue, divide issues after the bubble; back-to-back divide
        bus.id_valid = 1; bus.id_opcode = 4'b0011; bus.id_rs1 = 2; set_load(2);
        step();
        bus.ex_is_load = 0; bus.ex_reg_write = 0; bus.ex_rd = 0;
        step();
        repeat (DIVC - 1) step();
        step();
        set_idle();
        repeat (DIVC) step();

        // error in the third divide cycle
        bus.id_valid = 1; bus.id_opcode = 4'b0011;
        step();
        set_idle();
        step();
        step();
        bus.error_flag = 1;
        step();
        bus.error_flag = 0;
        repeat (20) step();
        rst = 1;
        step();
        rst = 0;
        step();

        // halt from RUN long enough to saturate the narrow counter
        bus.error_flag = 1;
        step();
        bus.error_flag = 0;
        repeat (20) step();
        rst = 1;
        step();
        rst = 0;

        for (int i = 0; i < 2000; i++) begin
            bus.id_valid     = ($urandom_range(0, 3) != 0);
            bus.id_opcode    = ($urandom_range(0, 3) == 0) ? 4'b0011 : 4'($urandom_range(0, 15));
            bus.id_rs1       = 4'($urandom_range(0, 3));
            bus.id_rs2       = 4'($urandom_range(0, 3));
            bus.id_uses_rs2  = 1'($urandom_range(0, 1));
            bus.ex_is_load   = ($urandom_range(0, 2) == 0);
            bus.ex_reg_write = ($urandom_range(0, 3) != 0);
            bus.ex_rd        = 4'($urandom_range(0, 3));
            bus.error_flag   = ($urandom_range(0, 149) == 0);
            if (m_mode == M_HALT) rst = ($urandom_range(0, 29) == 0);
            else                  rst = ($urandom_range(0, 299) == 0);
            step();
        end

        rst = 0;
        set_idle();
        step();
        @(negedge clk);
        #1;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain leftover=%0d want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_sequencer.md
Name: pipeline_hazard_sequencer

Overview:
Pipeline control block that sequences the 16-bit pipelined processor datapath around three events.
- Load-use hazards: stalls fetch and inserts a bubble into EX.
- Multi-cycle divides: freezes IF/ID and holds EX for the full divide latency.
- Error flag: halts the pipeline permanently until reset.
It sits beside the opcode decoder. It consumes ID/EX stage fields and the datapath error flag, and drives stall/bubble/hold controls back into the datapath pipeline registers.

Parameters:
REG_AW, 4, register-address width (16-entry register file).
DIV_OPCODE, 4'b0011, opcode of the multi-cycle divide.
DIV_CYCLES, 8, total EX occupancy of a divide in cycles; legal range 2..15.
CNT_W, 16, width of the stall-cycle statistics counter.

Ports:
clock  in  1  processor clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
id_valid  in  1  ID stage holds a real instruction
id_opcode  in  4  opcode in ID
id_rs1  in  REG_AW  source register 1 in ID
id_rs2  in  REG_AW  source register 2 in ID
id_uses_rs2  in  1  ID instruction actually reads rs2
ex_is_load  in  1  EX instruction is a memory load
ex_reg_write  in  1  EX instruction writes the register file
ex_rd  in  REG_AW  destination register in EX
error_flag  in  1  datapath error (x result or divide by zero)
stall_fetch  out  1  hold PC and IF/ID register
bubble_ex  out  1  load NOP into ID/EX register
ex_hold  out  1  hold ID/EX and EX state (divide in progress)
div_start  out  1  one-cycle pulse: divide issues from ID into EX at next edge
div_done  out  1  one-cycle pulse in the last held divide cycle
halted  out  1  pipeline halted by error
state  out  2  FSM state: RUN=00, DIV_BUSY=01, HALT=11 (10 unused, decodes to RUN)
stall_count  out  CNT_W  cycles with stall_fetch=1 since reset

Behaviour:
- Registered state: state, div counter (4 bits), stall_count. All other outputs are combinational from state and inputs.
- Reset: state=RUN, counter=0, stall_count=0. While reset is high, every output is forced to 0.
- Load-use hazard: id_valid & ex_is_load & ex_reg_write & (ex_rd!=0) & (ex_rd==id_rs1 | (id_uses_rs2 & ex_rd==id_rs2)).
- ex_rd=0 never produces a hazard.
- RUN state:
  - If a hazard is present: stall_fetch=1 and bubble_ex=1 in the same cycle, and div_start=0 (the hazard wins over divide issue). The bubble clears the hazard the next cycle, so at most 1 stall cycle per load.
  - Else if id_valid & id_opcode==DIV_OPCODE: div_start=1. Next state DIV_BUSY, counter loaded with DIV_CYCLES-1.
  - error_flag=1 takes priority for the next state: go to HALT. Combinational outputs in the current cycle are unaffected. A divide issued in that same cycle is abandoned.
- DIV_BUSY state:
  - stall_fetch=1, ex_hold=1, bubble_ex=0.
  - If counter==1: div_done=1, next state RUN. Otherwise counter decrements.
  - The state therefore lasts exactly DIV_CYCLES-1 cycles, so EX is occupied DIV_CYCLES cycles including the issue-following cycle.
  - No new divide is accepted in this state. Load-use is not evaluated (ID is frozen).
  - error_flag=1 moves to HALT next cycle and suppresses div_done.
- HALT state: stall_fetch=1, bubble_ex=1, ex_hold=0, halted=1. The only exit is reset.
- Back-to-back divides: the ID divide following a completed divide issues on the first RUN cycle after DIV_BUSY.
- stall_count increments on every cycle where stall_fetch=1, including HALT cycles. It saturates at all-ones and does not wrap.
- Reset asserted mid-divide or in HALT: returns to RUN on the next edge with the counter cleared. No div_done is emitted.

Test Plan:
1. Load-use on rs1: ex_is_load=1, ex_reg_write=1, ex_rd=5, id_rs1=5, id_valid=1 -> stall_fetch=bubble_ex=1 for that cycle only. With ex_rd=0 instead -> no stall.
2. rs2 gating: ex_rd=7, id_rs2=7 with id_uses_rs2=0 -> no stall; with id_uses_rs2=1 -> 1 stall cycle. stall_count=1.
3. Divide, DIV_CYCLES=8:
   - id_opcode=4'b0011, id_valid=1 -> div_start pulse.
   - Then state=01 for exactly 7 cycles with stall_fetch=ex_hold=1.
   - div_done high only in the 7th cycle, then RUN.
   - stall_count=7.
4. Priority: load-use hazard and divide opcode in ID together -> bubble, no div_start. div_start fires the following cycle.
5. Error mid-divide: error_flag=1 in the 3rd DIV_BUSY cycle -> HALT next cycle, halted=1, div_done never asserts. Stays halted for 20 cycles; reset -> state=00, stall_count=0.
6. Saturation (CNT_W=4 override): hold HALT for 20 cycles -> stall_count stops at 15.
